proc_mem_loader: RTL

Boot-time program loader sitting directly upstream of the processor top's external data-memory port. Accepts a stream of 32-bit instruction/data words over a valid/ready interface, writes them to consecutive word addresses through `ext_dmemreq_*`, and reads the region back to check a 32-bit additive checksum. It holds the processor in reset for the whole load and releases it only after a clean verify, so that processor-issued data requests (which win the memory mux) never collide with loader traffic.

---
 rtl/proc_mem_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/proc_mem_loader.sv
// Boot-time program loader: streams words into data memory, reads them back to
// verify an additive checksum, and holds the processor in reset until verify passes.
module proc_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
  parameter int unsigned MAX_WORDS = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [31:0] in_data,
  output logic        ext_dmemreq_val,
  output logic        ext_dmemreq_type,
  output logic [31:0] ext_dmemreq_addr,
  output logic [31:0] ext_dmemreq_wdata,
  input  logic [31:0] ext_dmemresp_rdata,
  output logic        proc_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_VERIFY = 3'd2,
    S_RUN    = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [15:0] len_r, len_s;
  logic [31:0] wsum_r, wsum_s;
  logic [31:0] rsum_r, rsum_s;
  logic        last_s;

  function automatic logic len_ok(input logic [15:0] l);
    len_ok = (l != 16'd0) && ({16'd0, l} <= MAX_WORDS);
  endfunction

  assign last_s = (cnt_r == (len_r - 16'd1));

  // Next-state, counter and checksum update
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    len_s   = len_r;
    wsum_s  = wsum_r;
    rsum_s  = rsum_r;
    case (state_r)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          if (len_ok(len)) begin
            len_s   = len;
            cnt_s   = 16'd0;
            wsum_s  = 32'd0;
            rsum_s  = 32'd0;
            state_s = S_WRITE;
          end else begin
            state_s = S_ERROR;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_WRITE: begin
        if (in_val) begin
          wsum_s = wsum_r + in_data;
          if (last_s) begin
            cnt_s   = 16'd0;
            state_s = S_VERIFY;
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_VERIFY: begin
        rsum_s = rsum_r + ext_dmemresp_rdata;
        if (last_s) begin
          cnt_s   = 16'd0;
          state_s = (rsum_s == wsum_r) ? S_RUN : S_ERROR;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 16'd0;
      len_r   <= 16'd0;
      wsum_r  <= 32'd0;
      rsum_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      len_r   <= len_s;
      wsum_r  <= wsum_s;
      rsum_r  <= rsum_s;
    end
  end

  assign ext_dmemreq_addr = BASE_ADDR + {14'd0, cnt_r, 2'b00};

  // Moore state decode; write request/data pass the stream through in WRITE
  always_comb begin
    in_rdy            = 1'b0;
    ext_dmemreq_val   = 1'b0;
    ext_dmemreq_type  = 1'b0;
    ext_dmemreq_wdata = 32'd0;
    proc_rst          = 1'b1;
    busy              = 1'b0;
    done              = 1'b0;
    err               = 1'b0;
    case (state_r)
      S_WRITE: begin
        in_rdy            = 1'b1;
        ext_dmemreq_val   = in_val;
        ext_dmemreq_type  = 1'b1;
        ext_dmemreq_wdata = in_data;
        busy              = 1'b1;
      end
      S_VERIFY: begin
        ext_dmemreq_val = 1'b1;
        busy            = 1'b1;
      end
      S_RUN: begin
        proc_rst = 1'b0;
        done     = 1'b1;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
        proc_rst = 1'b1;
      end
    endcase
  end

endmodule
